// File: rtl/mem_port_arbiter.sv
// Round-robin N-client arbiter sharing one MCB user port (cmd/wr/rd FIFOs), single-word transactions.
// Latency: write ack 3 cycles after grant; read ack the cycle after the rd word is popped.
// Backpressure: cmd/wr full and rd empty stall in place. ARB_TIMEOUT_EN adds a read-wait timeout.
module mem_port_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_BITS      = 30,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CLIENTS-1:0]           cl_req,
  input  logic [NUM_CLIENTS-1:0]           cl_we,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_addr,
  input  logic [NUM_CLIENTS*32-1:0]        cl_wdata,
  input  logic [NUM_CLIENTS*4-1:0]         cl_wmask,
  output logic [NUM_CLIENTS-1:0]           cl_ack,
  output logic [31:0]                      cl_rdata,
  output logic                             busy,
  output logic                             err,
  output logic                             mem_cmd_en,
  output logic [2:0]                       mem_cmd_instr,
  output logic [5:0]                       mem_cmd_bl,
  output logic [ADDR_BITS-1:0]             mem_cmd_byte_addr,
  input  logic                             mem_cmd_full,
  output logic                             mem_wr_en,
  output logic [3:0]                       mem_wr_mask,
  output logic [31:0]                      mem_wr_data,
  input  logic                             mem_wr_full,
  output logic                             mem_rd_en,
  input  logic [31:0]                      mem_rd_data,
  input  logic                             mem_rd_empty
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  if (NUM_CLIENTS < 1 || NUM_CLIENTS > 8 || ADDR_BITS < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PUSH,
    S_CMD,
    S_RD_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wmask;
  } req_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  req_t               req_q, req_d;
  logic [31:0]        rdata_q, rdata_d;
  req_t               cl_arr [NUM_CLIENTS];
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   rr_next;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign cl_arr[i].we    = cl_we[i];
    assign cl_arr[i].addr  = cl_addr[i*ADDR_BITS +: ADDR_BITS];
    assign cl_arr[i].wdata = cl_wdata[i*32 +: 32];
    assign cl_arr[i].wmask = cl_wmask[i*4 +: 4];
  end

  // Scan from rr_ptr upward, wrapping, and take the first active request.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    idx   = 0;
    idx_p = '0;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      idx_p = PTR_W'(idx);
      if (!found && cl_req[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  always_comb begin
    int nxt;
    nxt = int'(grant_q) + 1;
    if (nxt >= NUM_CLIENTS) nxt = 0;
    rr_next = PTR_W'(nxt);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    mem_wr_en  = 1'b0;
    mem_cmd_en = 1'b0;
    mem_rd_en  = 1'b0;
    cl_ack     = '0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d   = '0;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          req_d   = cl_arr[pick];
          state_d = cl_arr[pick].we ? S_WR_PUSH : S_CMD;
        end
      end
      S_WR_PUSH: begin
        mem_wr_en = !mem_wr_full;
        if (!mem_wr_full) state_d = S_CMD;
      end
      S_CMD: begin
        mem_cmd_en = !mem_cmd_full;
        if (!mem_cmd_full) state_d = req_q.we ? S_DONE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_rd_en = !mem_rd_empty;
        if (!mem_rd_empty) begin
          rdata_d = mem_rd_data;
          state_d = S_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the read but still ack, so the client is never wedged.
          err_d   = 1'b1;
          rdata_d = 32'hDEAD_BEEF;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        cl_ack[grant_q] = 1'b1;
        rr_ptr_d        = rr_next;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy              = (state_q != S_IDLE);
  assign cl_rdata          = rdata_q;
  assign mem_cmd_instr     = req_q.we ? 3'b000 : 3'b001;
  assign mem_cmd_bl        = 6'd0;
  assign mem_cmd_byte_addr = {req_q.addr[ADDR_BITS-1:2], 2'b00};
  assign mem_wr_mask       = req_q.wmask;
  assign mem_wr_data       = req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (4 clients, 16-cycle read timeout when enabled).
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AB = 30;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    cl_req;
  logic [N-1:0]    cl_we;
  logic [N*AB-1:0] cl_addr;
  logic [N*32-1:0] cl_wdata;
  logic [N*4-1:0]  cl_wmask;
  logic [N-1:0]    cl_ack;
  logic [31:0]     cl_rdata;
  logic            busy;
  logic            err;
  logic            mem_cmd_en;
  logic [2:0]      mem_cmd_instr;
  logic [5:0]      mem_cmd_bl;
  logic [AB-1:0]   mem_cmd_byte_addr;
  logic            mem_cmd_full;
  logic            mem_wr_en;
  logic [3:0]      mem_wr_mask;
  logic [31:0]     mem_wr_data;
  logic            mem_wr_full;
  logic            mem_rd_en;
  logic [31:0]     mem_rd_data;
  logic            mem_rd_empty;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.NUM_CLIENTS(N), .ADDR_BITS(AB), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata), .cl_wmask(cl_wmask),
    .cl_ack(cl_ack), .cl_rdata(cl_rdata), .busy(busy), .err(err),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
    .mem_wr_full(mem_wr_full),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int c, input logic we, input logic [AB-1:0] a,
                            input logic [31:0] d, input logic [3:0] m);
    cl_we[c]           = we;
    cl_addr[c*AB +: AB] = a;
    cl_wdata[c*32 +: 32] = d;
    cl_wmask[c*4 +: 4]  = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cl_req = '0; cl_we = '0; cl_addr = '0; cl_wdata = '0; cl_wmask = '0;
    mem_cmd_full = 1'b0; mem_wr_full = 1'b0; mem_rd_empty = 1'b1; mem_rd_data = '0;
    tick; tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cl_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", cl_ack); end
    checks++; if (cl_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cl_rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++;
    if ({mem_cmd_en, mem_wr_en, mem_rd_en} !== 3'b000) begin
      errors++; $display("FAIL reset_enables: got %b want 000", {mem_cmd_en, mem_wr_en, mem_rd_en});
    end
    rst_n = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_write;
    set_client(2, 1'b1, 30'h103, 32'hA5A5_0001, 4'h0);
    cl_req = 4'b0100;
    tick;  // granted -> WR_PUSH
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wr_data !== 32'hA5A5_0001 || mem_wr_mask !== 4'h0) begin
      errors++; $display("FAIL write_push: en=%b data=%h mask=%h want 1 a5a50001 0", mem_wr_en, mem_wr_data, mem_wr_mask);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    tick;  // CMD
    checks++;
    if (mem_cmd_en !== 1'b1 || mem_cmd_instr !== 3'b000 || mem_cmd_byte_addr !== 30'h100 || mem_cmd_bl !== 6'd0) begin
      errors++; $display("FAIL write_cmd: en=%b instr=%b addr=%h bl=%0d want 1 000 100 0",
                         mem_cmd_en, mem_cmd_instr, mem_cmd_byte_addr, mem_cmd_bl);
    end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL write_wr_once: got %b want 0", mem_wr_en); end
    tick;  // DONE, 3 cycles after grant
    checks++; if (cl_ack !== 4'b0100) begin errors++; $display("FAIL write_ack: got %b want 0100", cl_ack); end
    cl_req = '0;
    tick;
    checks++;
    if (cl_ack !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL write_ack_pulse: ack=%b busy=%b want 0000 0", cl_ack, busy);
    end
  endtask

  task automatic test_read;
    set_client(1, 1'b0, 30'h2000_0044, 32'h0, 4'h0);
    cl_req = 4'b0010;
    tick;  // CMD
    checks++;
    if (mem_cmd_en !== 1'b1 || mem_cmd_instr !== 3'b001 || mem_cmd_byte_addr !== 30'h2000_0044) begin
      errors++; $display("FAIL read_cmd: en=%b instr=%b addr=%h want 1 001 20000044", mem_cmd_en, mem_cmd_instr, mem_cmd_byte_addr);
    end
    tick;  // RD_WAIT
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_rd_en !== 1'b0 || cl_ack !== 4'b0) begin
        errors++; $display("FAIL read_wait_%0d: rd_en=%b ack=%b want 0 0000", i, mem_rd_en, cl_ack);
      end
      tick;
    end
    mem_rd_data = 32'h1234_5678; mem_rd_empty = 1'b0;
    #1;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL read_pop: got %b want 1", mem_rd_en); end
    tick;  // DONE
    mem_rd_empty = 1'b1;
    #1;
    checks++;
    if (cl_ack !== 4'b0010 || cl_rdata !== 32'h1234_5678 || mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL read_ack: ack=%b rdata=%h rd_en=%b want 0010 12345678 0", cl_ack, cl_rdata, mem_rd_en);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err); end
    cl_req = '0;
    tick;
  endtask

  // rr_ptr is 2 here; the reset must bring it back to 0 so client 1 beats client 3.
  task automatic test_reset_mid;
    int n;
    set_client(3, 1'b0, 30'h40, 32'h0, 4'h0);
    cl_req = 4'b1000;
    tick; tick;  // CMD, RD_WAIT
    checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL rdwait_state: busy=%b rd_en=%b want 1 0", busy, mem_rd_en);
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || cl_ack !== 4'b0 || cl_rdata !== 32'h0) begin
      errors++; $display("FAIL midreset: busy=%b ack=%b rdata=%h want 0 0000 0", busy, cl_ack, cl_rdata);
    end
    cl_req = '0; rst_n = 1'b1;
    tick;
    set_client(1, 1'b1, 30'h10, 32'h11, 4'h0);
    set_client(3, 1'b1, 30'h30, 32'h33, 4'h0);
    cl_req = 4'b1010;
    n = 0;
    while (cl_ack === 4'b0 && n < 10) begin tick; n++; end
    checks++; if (cl_ack !== 4'b0010) begin errors++; $display("FAIL midreset_ptr_first: ack=%b want 0010", cl_ack); end
    cl_req[1] = 1'b0;
    tick;
    n = 0;
    while (cl_ack === 4'b0 && n < 10) begin tick; n++; end
    checks++; if (cl_ack !== 4'b1000) begin errors++; $display("FAIL midreset_ptr_second: ack=%b want 1000", cl_ack); end
    cl_req = '0;
    tick;
  endtask

  task automatic test_round_robin;
    int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) set_client(c, 1'b1, AB'(c * 256), 32'hC0DE_0000 + c, 4'h0);
    cl_req = 4'b1111;
    tick;
    rst_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      exp_ack = 4'b0001 << exp_order[r];
      n = 0;
      while (mem_wr_en !== 1'b1 && n < 10) begin tick; n++; end
      checks++;
      if (mem_wr_data !== 32'hC0DE_0000 + exp_order[r]) begin
        errors++; $display("FAIL rr_data_%0d: got %h want %h", r, mem_wr_data, 32'hC0DE_0000 + exp_order[r]);
      end
      n = 0;
      while (cl_ack === 4'b0 && n < 10) begin tick; n++; end
      checks++; if (cl_ack !== exp_ack) begin errors++; $display("FAIL rr_ack_%0d: got %b want %b", r, cl_ack, exp_ack); end
      if (r == 4) cl_req = '0;
      tick;
    end
  endtask

  task automatic test_backpressure;
    set_client(3, 1'b1, 30'h0FFF, 32'hBEEF_0003, 4'b0101);
    mem_wr_full = 1'b1; mem_cmd_full = 1'b1;
    cl_req = 4'b1000;
    tick;  // WR_PUSH, stalled
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_wr_en !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL wr_stall_%0d: wr_en=%b busy=%b want 0 1", i, mem_wr_en, busy);
      end
      tick;
    end
    mem_wr_full = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wr_data !== 32'hBEEF_0003 || mem_wr_mask !== 4'b0101) begin
      errors++; $display("FAIL wr_after_stall: en=%b data=%h mask=%b want 1 beef0003 0101", mem_wr_en, mem_wr_data, mem_wr_mask);
    end
    tick;  // CMD, stalled
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mem_cmd_en !== 1'b0 || cl_ack !== 4'b0) begin
        errors++; $display("FAIL cmd_stall_%0d: cmd_en=%b ack=%b want 0 0000", i, mem_cmd_en, cl_ack);
      end
      tick;
    end
    mem_cmd_full = 1'b0;
    #1;
    checks++;
    if (mem_cmd_en !== 1'b1 || mem_cmd_byte_addr !== 30'hFFC || mem_cmd_instr !== 3'b000) begin
      errors++; $display("FAIL cmd_after_stall: en=%b addr=%h instr=%b want 1 ffc 000", mem_cmd_en, mem_cmd_byte_addr, mem_cmd_instr);
    end
    tick;
    checks++; if (cl_ack !== 4'b1000) begin errors++; $display("FAIL bp_ack: got %b want 1000", cl_ack); end
    cl_req = '0;
    tick;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    set_client(0, 1'b0, 30'h80, 32'h0, 4'h0);
    mem_rd_empty = 1'b1;
    cl_req = 4'b0001;
    tick; tick;  // CMD, RD_WAIT
    n = 0;
    while (cl_ack === 4'b0 && n < 40) begin tick; n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", n); end
    checks++;
    if (cl_ack !== 4'b0001 || cl_rdata !== 32'hDEAD_BEEF || err !== 1'b1) begin
      errors++; $display("FAIL timeout_ack: ack=%b rdata=%h err=%b want 0001 deadbeef 1", cl_ack, cl_rdata, err);
    end
    cl_req = '0;
    tick; tick;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky: err=%b busy=%b want 1 0", err, busy); end
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read;
    test_reset_mid;
    test_round_robin;
    test_backpressure;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
